// File: rtl/mul_issue_ctrl.sv
// rtl/mul_issue_ctrl.sv - two-requester issue controller for a fixed-latency pipelined multiplier
// Round-robin issue, tag/half-select tracking pipeline and a credit-protected result FIFO.
module mul_issue_ctrl #(
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req0_signed,
    input  logic             req0_high,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic             req1_signed,
    input  logic             req1_high,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      mul_in0,
    output logic [31:0]      mul_in1,
    output logic             mul_signed,
    input  logic [63:0]      mul_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_src
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [CW-1:0]    fifo_count;
    logic [CW-1:0]    inflight_count;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [31:0]      mem_data [FIFO_DEPTH];
    logic [TAG_W-1:0] mem_tag  [FIFO_DEPTH];
    logic             mem_src  [FIFO_DEPTH];

    logic             pipe_valid [LATENCY];
    logic             pipe_high  [LATENCY];
    logic [TAG_W-1:0] pipe_tag   [LATENCY];
    logic             pipe_src   [LATENCY];

    logic        prio;
    logic        credit;
    logic        grant0;
    logic        grant1;
    logic        grant;
    logic        exit_valid;
    logic        pop;
    logic [31:0] res_word;

    // Every granted-but-unpopped op owns a FIFO slot, so the buffer can never overflow.
    assign credit = en && !reset &&
                    (({1'b0, fifo_count} + {1'b0, inflight_count}) < DEPTH_C);

    assign grant0 = credit && req0_valid && (!prio || !req1_valid);
    assign grant1 = credit && req1_valid && ( prio || !req0_valid);
    assign grant  = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign mul_in0    = grant1 ? req1_a      : (grant0 ? req0_a      : 32'd0);
    assign mul_in1    = grant1 ? req1_b      : (grant0 ? req0_b      : 32'd0);
    assign mul_signed = grant1 ? req1_signed : (grant0 ? req0_signed : 1'b0);

    assign exit_valid = pipe_valid[LATENCY-1];
    assign res_word   = pipe_high[LATENCY-1] ? mul_out[63:32] : mul_out[31:0];

    assign res_valid = !reset && (fifo_count != '0);
    assign res_data  = mem_data[rd_ptr];
    assign res_tag   = mem_tag[rd_ptr];
    assign res_src   = mem_src[rd_ptr];
    assign pop       = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
            end
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            inflight_count <= '0;
            prio           <= 1'b0;
        end else begin
            pipe_valid[0] <= grant;
            pipe_high[0]  <= grant1 ? req1_high : req0_high;
            pipe_tag[0]   <= grant1 ? req1_tag  : req0_tag;
            pipe_src[0]   <= grant1;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_high[i]  <= pipe_high[i-1];
                pipe_tag[i]   <= pipe_tag[i-1];
                pipe_src[i]   <= pipe_src[i-1];
            end

            if (grant) begin
                prio <= !grant1;
            end

            case ({grant, exit_valid})
                2'b10:   inflight_count <= inflight_count + 1'b1;
                2'b01:   inflight_count <= inflight_count - 1'b1;
                default: inflight_count <= inflight_count;
            endcase

            // The product is captured in the very cycle its tag entry leaves the pipeline.
            if (exit_valid) begin
                mem_data[wr_ptr] <= res_word;
                mem_tag[wr_ptr]  <= pipe_tag[LATENCY-1];
                mem_src[wr_ptr]  <= pipe_src[LATENCY-1];
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({exit_valid, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb/tb_mul_issue_ctrl.sv - self-checking bench for mul_issue_ctrl
// Multiplier model, in-order scoreboard with ready-time stamps and per-scenario tasks.
module tb_mul_issue_ctrl;
    localparam int LATENCY    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int TAG_W      = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1, en = 1'b0, res_ready = 1'b1;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic             req0_signed = 1'b0, req0_high = 1'b0, req1_signed = 1'b0, req1_high = 1'b0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic [31:0]      mul_in0, mul_in1;
    logic             mul_signed;
    logic [63:0]      mul_out;
    logic             res_valid;
    logic [31:0]      res_data;
    logic [TAG_W-1:0] res_tag;
    logic             res_src;

    int errors = 0;
    int checks = 0;

    mul_issue_ctrl #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .en(en),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_signed(req0_signed), .req0_high(req0_high), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_signed(req1_signed), .req1_high(req1_high), .req1_tag(req1_tag),
        .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_signed(mul_signed), .mul_out(mul_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_src(res_src)
    );

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic signed [63:0] sa, sb_v;
        if (s) begin
            sa   = $signed({{32{a[31]}}, a});
            sb_v = $signed({{32{b[31]}}, b});
            return sa * sb_v;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input logic h);
        logic [63:0] p;
        p = prod(a, b, s);
        return h ? p[63:32] : p[31:0];
    endfunction

    // Fixed-latency multiplier: product appears LATENCY cycles after the operands.
    logic [63:0] mstage [LATENCY];
    always @(posedge clk) begin
        mstage[0] <= prod(mul_in0, mul_in1, mul_signed);
        for (int i = 1; i < LATENCY; i++) mstage[i] <= mstage[i-1];
    end
    assign mul_out = mstage[LATENCY-1];

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             src;
        int               rdy;
    } ent_t;

    ent_t sb[$];
    bit   mptr = 1'b0;
    int   cyc  = 0;

    // Reference: outstanding ops = granted minus popped; results ready LATENCY+1 cycles after grant.
    always @(negedge clk) begin
        bit   allow, eg0, eg1, ev;
        ent_t e;
        cyc++;
        if (reset) begin
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b0 ||
                mul_in0 !== 32'd0 || mul_in1 !== 32'd0 || mul_signed !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs rdy=%b%b res_valid=%b mul=%h/%h/%b required all zero",
                         req0_ready, req1_ready, res_valid, mul_in0, mul_in1, mul_signed);
            end
            sb.delete();
            mptr = 1'b0;
        end else begin
            allow = en && (sb.size() < FIFO_DEPTH);
            eg0   = allow && req0_valid && (!mptr || !req1_valid);
            eg1   = allow && req1_valid && ( mptr || !req0_valid);
            checks++;
            if ({req0_ready, req1_ready} !== {eg0, eg1}) begin
                errors++;
                $display("FAIL grant cyc=%0d got=%b%b required=%b%b", cyc, req0_ready, req1_ready, eg0, eg1);
            end
            ev = (sb.size() > 0) && (sb[0].rdy <= cyc);
            checks++;
            if (res_valid !== ev) begin
                errors++;
                $display("FAIL res_valid cyc=%0d got=%b required=%b", cyc, res_valid, ev);
            end
            if (ev && res_valid === 1'b1) begin
                checks++;
                if (res_data !== sb[0].data || res_tag !== sb[0].tag || res_src !== sb[0].src) begin
                    errors++;
                    $display("FAIL result cyc=%0d got=%h/%h/%b required=%h/%h/%b", cyc,
                             res_data, res_tag, res_src, sb[0].data, sb[0].tag, sb[0].src);
                end
                if (res_ready) void'(sb.pop_front());
            end
            checks++;
            if (eg0 || eg1) begin
                e.data = eg1 ? exp_word(req1_a, req1_b, req1_signed, req1_high)
                             : exp_word(req0_a, req0_b, req0_signed, req0_high);
                e.tag  = eg1 ? req1_tag : req0_tag;
                e.src  = eg1;
                e.rdy  = cyc + LATENCY + 1;
                if (mul_in0 !== (eg1 ? req1_a : req0_a) || mul_in1 !== (eg1 ? req1_b : req0_b) ||
                    mul_signed !== (eg1 ? req1_signed : req0_signed)) begin
                    errors++;
                    $display("FAIL mul_operands cyc=%0d got=%h/%h/%b for src %0d", cyc,
                             mul_in0, mul_in1, mul_signed, eg1);
                end
                sb.push_back(e);
                mptr = !eg1;
            end else if (mul_in0 !== 32'd0 || mul_in1 !== 32'd0 || mul_signed !== 1'b0) begin
                errors++;
                $display("FAIL mul_idle cyc=%0d got=%h/%h/%b required zero", cyc, mul_in0, mul_in1, mul_signed);
            end
        end
    end

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'd3; req0_b = 32'd4; req0_tag = 4'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL test_reset got rdy=%b%b res_valid=%b required 000", req0_ready, req1_ready, res_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL first_grant_after_reset got=%b required=1", req0_ready);
        end
        @(posedge clk); #1;
        idle(10);
    endtask

    task automatic test_signed_low();
        int lat = 0;
        bit seen = 0;
        req0_valid = 1'b1; req0_a = 32'd27; req0_b = 32'hFFFF_FFE1;
        req0_signed = 1'b1; req0_high = 1'b0; req0_tag = 4'd5;
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL signed_grant got=%b required=1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (res_valid === 1'b1) seen = 1;
        end
        checks++;
        if (lat !== 4 || res_data !== 32'hFFFF_FCBB || res_tag !== 4'd5 || res_src !== 1'b0) begin
            errors++;
            $display("FAIL signed_low got lat=%0d data=%h tag=%h src=%b required lat=4 data=fffffcbb tag=5 src=0",
                     lat, res_data, res_tag, res_src);
        end
        idle(6);
    endtask

    task automatic test_unsigned();
        logic [31:0] d[$];
        bit          s[$];
        req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_b = 32'hFFFF_FFFF;
        req1_signed = 1'b0; req1_high = 1'b1; req1_tag = 4'd9;
        @(posedge clk); #1;
        req1_high = 1'b0; req1_tag = 4'd10;
        @(posedge clk); #1;
        req1_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (res_valid === 1'b1 && res_ready) begin
                d.push_back(res_data);
                s.push_back(res_src);
            end
        end
        checks++;
        if (d.size() != 2) begin
            errors++;
            $display("FAIL unsigned_count got=%0d required=2", d.size());
        end else begin
            checks++;
            if (d[0] !== 32'hFFFF_FFFE || d[1] !== 32'h0000_0001 || s[0] !== 1'b1 || s[1] !== 1'b1) begin
                errors++;
                $display("FAIL unsigned_data got=%h,%h src=%b%b required=fffffffe,00000001 src=11",
                         d[0], d[1], s[0], s[1]);
            end
        end
        idle(2);
    endtask

    task automatic test_contention();
        int src_q[$];
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req0_a = $urandom; req0_b = $urandom; req0_tag = TAG_W'(i);
            req1_a = $urandom; req1_b = $urandom; req1_tag = TAG_W'(i + 8);
            req0_signed = $urandom_range(0, 1); req1_high = $urandom_range(0, 1);
            @(negedge clk);
            if (req0_ready === 1'b1) src_q.push_back(0);
            else if (req1_ready === 1'b1) src_q.push_back(1);
            @(posedge clk); #1;
        end
        idle(12);
        checks++;
        if (src_q.size() < 6) begin
            errors++;
            $display("FAIL contention_grants got=%0d required>=6", src_q.size());
        end
        for (int i = 1; i < src_q.size(); i++) begin
            checks++;
            if (src_q[i] == src_q[i-1]) begin
                errors++;
                $display("FAIL contention_alternate idx=%0d got=%0d required=%0d", i, src_q[i], 1 - src_q[i-1]);
            end
        end
    endtask

    task automatic test_backpressure();
        int g = 0, g2 = 0, p = 0;
        res_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req0_tag = TAG_W'(i); req1_tag = TAG_W'(15 - i);
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) g++;
            @(posedge clk); #1;
        end
        checks++;
        if (g != FIFO_DEPTH) begin
            errors++;
            $display("FAIL backpressure_grants got=%0d required=%0d", g, FIFO_DEPTH);
        end
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) g2++;
            if (res_valid === 1'b1) p++;
            @(posedge clk); #1;
        end
        idle(12);
        checks++;
        if (p < FIFO_DEPTH || g2 == 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL backpressure_drain got pops=%0d grants=%0d left=%0d required pops>=4 grants>0 left=0",
                     p, g2, sb.size());
        end
    endtask

    task automatic test_reset_midflight();
        int g = 0, v = 0;
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req0_a = $urandom; req0_tag = TAG_W'(i);
            @(negedge clk);
            if (req0_ready === 1'b1) g++;
            @(posedge clk); #1;
        end
        req0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b0) v++;
        end
        checks++;
        if (g != 3 || v != 0) begin
            errors++;
            $display("FAIL reset_midflight got grants=%0d stale_valid_cycles=%0d required 3 and 0", g, v);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_en_low();
        int g = 0, p = 0;
        en = 1'b1; res_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req0_a = $urandom; req1_a = $urandom;
            @(negedge clk);
            if (req0_ready === 1'b1 || req1_ready === 1'b1) g++;
            if (res_valid === 1'b1) p++;
            @(posedge clk); #1;
            if (g >= 2) en = 1'b0;
        end
        checks++;
        if (g != 2 || p != 2) begin
            errors++;
            $display("FAIL en_low got grants=%0d results=%0d required 2 and 2", g, p);
        end
        en = 1'b1;
        idle(2);
    endtask

    task automatic test_random();
        logic [31:0] edge_v [4];
        edge_v[0] = 32'd0; edge_v[1] = 32'hFFFF_FFFF; edge_v[2] = 32'h8000_0000; edge_v[3] = 32'd1;
        for (int i = 0; i < 600; i++) begin
            req0_valid  = ($urandom_range(0, 9) < 6);
            req1_valid  = ($urandom_range(0, 9) < 6);
            en          = ($urandom_range(0, 9) < 9);
            res_ready   = ($urandom_range(0, 9) < 6);
            req0_a      = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            req0_b      = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            req1_a      = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            req1_b      = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 3)] : $urandom;
            req0_signed = $urandom_range(0, 1); req0_high = $urandom_range(0, 1);
            req1_signed = $urandom_range(0, 1); req1_high = $urandom_range(0, 1);
            req0_tag    = TAG_W'($urandom); req1_tag = TAG_W'($urandom);
            @(posedge clk); #1;
        end
        en = 1'b1; res_ready = 1'b1;
        idle(20);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL random_drain got outstanding=%0d required=0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_signed_low();
        test_unsigned();
        test_contention();
        test_backpressure();
        test_reset_midflight();
        test_en_low();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 Parameter LATENCY, default 3: cycles from operands driven on mul_in0/mul_in1 to product valid on mul_out.
REQ-002 Parameter FIFO_DEPTH, default 4: result buffer entries; power of two, at least 2.
REQ-003 Parameter TAG_W, default 4: requester tag width.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 en  in  1  issue enable; when low, no new grants are made.
REQ-007 req0_valid / req1_valid  in  1 each  requester has an operation pending.
REQ-008 req0_ready / req1_ready  out  1 each  grant; the operation transfers when valid and ready are both high.
REQ-009 reqN_a, reqN_b  in  32 each  operands (N = 0, 1).
REQ-010 reqN_signed  in  1  1 = signed x signed, 0 = unsigned x unsigned.
REQ-011 reqN_high  in  1  1 = return product[63:32], 0 = return product[31:0].
REQ-012 reqN_tag  in  TAG_W  opaque tag, returned with the result.
REQ-013 mul_in0, mul_in1  out  32 each  operands driven to the multiplier.
REQ-014 mul_signed  out  1  signedness driven to the multiplier.
REQ-015 mul_out  in  64  multiplier product, valid exactly LATENCY cycles after issue.
REQ-016 res_valid  out  1  result available.
REQ-017 res_ready  in  1  consumer accepts the result.
REQ-018 res_data  out  32  selected product half.
REQ-019 res_tag  out  TAG_W  tag of the result.
REQ-020 res_src  out  1  index of the originating requester.

Function
REQ-021 At most one grant per cycle; the multiplier accepts one operation per cycle and cannot stall.
REQ-022 Issue is permitted only when en=1 and fifo_count + inflight_count < FIFO_DEPTH, using counts registered at the start of the cycle.
  - A same-cycle pop is not credited.
  - The buffer therefore never overflows.
REQ-023 Round-robin arbitration:
  - Priority pointer resets to requester 0.
  - After a grant, the pointer moves to the other requester.
  - If only one requester is valid, it is granted regardless of the pointer.
REQ-024 reqN_ready is combinational from the pointer, the credit check and reqN_valid; it is never high for both requesters in the same cycle.
REQ-025 On a grant, mul_in0, mul_in1 and mul_signed equal the granted operands in that cycle; with no grant they are driven to 0.
REQ-026 Each grant pushes {valid, high, tag, src} into a LATENCY-deep shift pipeline; entries advance every cycle, with no bubble collapsing.
REQ-027 When the pipeline output entry is valid, mul_out is sampled that cycle:
  - res word = high ? mul_out[63:32] : mul_out[31:0];
  - the word is written with tag and src into the FIFO.
REQ-028 inflight_count is incremented on a grant and decremented on a pipeline exit; a simultaneous grant and exit leaves it unchanged.
REQ-029 FIFO behaviour:
  - Registered output; a pop occurs when res_valid and res_ready are both high.
  - A push into an empty FIFO first appears on res_valid the next cycle; there is no bypass.
  - A simultaneous push and pop is legal at any occupancy, and the count is unchanged.
REQ-030 Read and write pointers wrap modulo FIFO_DEPTH.
REQ-031 res_data, res_tag and res_src hold stable while res_valid=1 and res_ready=0.
REQ-032 en=0 does not stop the pipeline or FIFO: in-flight operations complete and results drain normally.
REQ-033 Results leave the block in grant order.

Reset
REQ-034 While reset=1, the following are forced:
  - pipeline valid bits and FIFO pointers/count cleared;
  - inflight_count = 0;
  - priority pointer = requester 0;
  - outputs: res_valid=0, req0_ready=0, req1_ready=0, mul_in0=0, mul_in1=0, mul_signed=0.
REQ-035 Reset asserted mid-operation discards all in-flight and buffered results; no result from before reset appears afterwards.
REQ-036 Grants may resume on the first cycle after reset deasserts.

Verification
REQ-037 Signed, low word: req0 a=27, b=-31 (0xFFFFFFE1), signed=1, high=0, tag=5 -> res_valid 4 cycles after the grant; res_data=0xFFFFFCBB, res_tag=5, res_src=0.
REQ-038 Unsigned: req1 a=b=0xFFFFFFFF, signed=0, high=1 -> res_data=0xFFFFFFFE; the same operands with high=0 -> 0x00000001.
REQ-039 Contention: both requesters valid continuously for 8 cycles with res_ready=1 -> grants alternate 0,1,0,1,...; results return in the same order with matching tags.
REQ-040 Backpressure: res_ready=0 with both requesters valid -> exactly 4 grants, then the ready signals stay low; raise res_ready -> one result per cycle and issue resumes; no result is lost or duplicated.
REQ-041 Reset mid-flight: issue 3 operations, assert reset for 1 cycle while they are in the pipeline -> res_valid stays 0 afterwards until new operations are issued.
REQ-042 en=0 after 2 grants -> no further grants; both results are still delivered.
